ram_nxm: RTL
============

# ram_nxm

Parametrised single-port synchronous RAM: the next-generation successor to the fixed 8×16 register RAM. Width and depth are set by parameters. Reads are registered with a valid strobe. The output holds its value when no read is in progress. A built-in clear sequencer zeroes the array after reset or on request. It sits between the datapath register bus and the control unit as general scratch/data storage.

## Interface
- `WIDTH`, 16, data word width in bits (≥1)
- `DEPTH`, 8, number of words (≥2; need not be a power of two)
- `AW`, `$clog2(DEPTH)`, address width (derived; not overridden)

Ports:
- `CLK`  in  1  rising-edge clock
- `RST_N`  in  1  reset, asynchronous assert, active-low
- `E`  in  1  chip enable; gates `W` and `R`
- `W`  in  1  write request (effective when `E`=1)
- `R`  in  1  read request (effective when `E`=1)
- `ADDR`  in  AW  word address
- `D`  in  WIDTH  write data
- `CLR`  in  1  clear request, single-cycle pulse
- `OUT`  out  WIDTH  registered read data
- `OUT_VALID`  out  1  one-cycle pulse; `OUT` updated this cycle
- `BUSY`  out  1  clear in progress; accesses ignored
- `OOR`  out  1  one-cycle pulse; access to `ADDR` ≥ DEPTH was rejected

## Operation
- States: `CLEAR` and `IDLE`.
- Reset (`RST_N`=0, async):
  - state=`CLEAR`, clear counter=0
  - `OUT`=0, `OUT_VALID`=0, `OOR`=0, `BUSY`=1
  - Array contents are not touched by reset itself.
- `CLEAR` state:
  - Each rising edge writes 0 to mem[counter] and increments the counter.
  - On the edge that writes DEPTH-1, go to `IDLE`; `BUSY`=0 after that edge.
  - `E`, `W`, `R`, `CLR` are ignored: no write, no `OUT_VALID`, no `OOR`.
- `IDLE`, write (`E`&`W`): mem[`ADDR`]←`D` on the edge.
- `IDLE`, read (`E`&`R`): `OUT`←mem[`ADDR`] on the edge; `OUT_VALID`=1 for that one cycle.
- `IDLE`, no read: `OUT` holds its last value; `OUT_VALID`=0.
- `W`&`R` same cycle: both happen, read-first (`OUT` gets the old word, the array gets `D`).
- `ADDR` ≥ DEPTH with `E`&(`W`|`R`):
  - Write suppressed, `OUT` unchanged, `OUT_VALID`=0, `OOR`=1 for one cycle.
- `CLR`=1 in `IDLE`:
  - Counter→0, state→`CLEAR`.
  - A same-cycle `W`/`R` is dropped (`CLR` has priority).
- Reset asserted mid-clear: counter returns to 0; the full clear reruns after release.

## Timing
- Read latency is 1 cycle: request sampled at edge N; `OUT`/`OUT_VALID` valid after edge N, through edge N+1.
- Write visible to a read request issued on the next edge.
- Clear duration:
  - `BUSY` stays high for exactly DEPTH rising edges after `RST_N` release.
  - `BUSY` rises on the edge after a `CLR` pulse and stays high for DEPTH edges.
  - First accepted access: the edge following the edge that drops `BUSY`.
- `OOR` and `OUT_VALID` are never both 1.
- All outputs are registered; no combinational input→output path.

## Structure
- Shared package `ram_pkg`:
  - state enum {`CLEAR`, `IDLE`}
  - `RAM_WIDTH_DEF`=16, `RAM_DEPTH_DEF`=8
- Sub-module `ram_clear_ctrl`:
  - Holds the state register and the clear counter.
  - Outputs the clear write-enable, clear address and `BUSY`.
- The top level holds the array, access gating, read register and `OOR` logic.

## Test plan
- Reset release, WIDTH=16, DEPTH=8:
  - `BUSY`=1 for 8 cycles, then 0.
  - Reads of addresses 0..7 return 0x0000 with `OUT_VALID` pulses.
- Write 0xBEEF@3 then read @3:
  - `OUT`=0xBEEF one cycle after the read, `OUT_VALID`=1.
  - `OUT` still 0xBEEF with `OUT_VALID`=0 on the following idle cycle.
- Read-during-write: mem[5]=0x1111, then one cycle with `W`&`R`, `ADDR`=5, `D`=0x2222:
  - `OUT`=0x1111.
  - A following read returns 0x2222.
- DEPTH=6: write @7 then read @7:
  - `OOR` pulses each time; `OUT` unchanged; mem[0..5] unmodified.
- `CLR` pulse after filling memory, with a write attempted during `BUSY`:
  - `BUSY` high 8 cycles.
  - The write is ignored; all words read 0 afterward.
- Reset asserted at clear counter=4, released 2 cycles later:
  - `OUT`=0 and `BUSY`=1 immediately.
  - `BUSY` then lasts a full 8 cycles after release.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared definitions for the parametrised scratch RAM.
//   RAM_WIDTH_DEF / RAM_DEPTH_DEF : default word width and word count
//   ram_state_e                   : clear-sequencer state
package ram_pkg;
  localparam int RAM_WIDTH_DEF = 16;
  localparam int RAM_DEPTH_DEF = 8;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } ram_state_e;
endpackage

// File: rtl/ram_nxm_if.sv
// Access bus for ram_nxm.
//   master : drives e, w, r, addr, d, clr; receives out, out_valid, busy, oor
//   slave  : the RAM side of the same signals
interface ram_nxm_if
  import ram_pkg::*;
#(
  parameter int WIDTH = RAM_WIDTH_DEF,
  parameter int AW    = $clog2(RAM_DEPTH_DEF)
);
  logic             e;
  logic             w;
  logic             r;
  logic [AW-1:0]    addr;
  logic [WIDTH-1:0] d;
  logic             clr;
  logic [WIDTH-1:0] out;
  logic             out_valid;
  logic             busy;
  logic             oor;

  modport master (
    output e, w, r, addr, d, clr,
    input  out, out_valid, busy, oor
  );

  modport slave (
    input  e, w, r, addr, d, clr,
    output out, out_valid, busy, oor
  );
endinterface

// File: rtl/ram_clear_ctrl.sv
// Clear sequencer: walks the array writing zeros after reset or on clr.
//   clk, rst_n : clock, async active-low reset (restarts the clear)
//   clr        : clear request, honoured only when idle
//   clr_we     : zero-write enable for the array
//   clr_addr   : address being zeroed
//   busy       : clear in progress
//
//   state | meaning
//   CLEAR | zeroing mem[cnt]; accesses are ignored
//   IDLE  | normal read/write service
module ram_clear_ctrl
  import ram_pkg::*;
#(
  parameter int DEPTH = RAM_DEPTH_DEF,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr,
  output logic          busy
);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  ram_state_e    state, state_nxt;
  logic [AW-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      CLEAR: begin
        if (cnt == LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + AW'(1);
        end
      end
      IDLE: begin
        if (clr) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = CLEAR;
        cnt_nxt   = '0;
      end
    endcase
  end

  // busy comes straight off the state flop, so it stays registered.
  assign clr_we   = (state == CLEAR);
  assign clr_addr = cnt;
  assign busy     = (state == CLEAR);
endmodule

// File: rtl/ram_nxm.sv
// Parametrised single-port synchronous RAM with registered read and a
// built-in clear sequencer.
//   clk, rst_n : clock, async active-low reset
//   bus        : ram_nxm_if slave (e/w/r/addr/d/clr in; out/out_valid/busy/oor out)
module ram_nxm
  import ram_pkg::*;
#(
  parameter int WIDTH = RAM_WIDTH_DEF,
  parameter int DEPTH = RAM_DEPTH_DEF,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic     clk,
  input  logic     rst_n,
  ram_nxm_if.slave bus
);
  localparam logic [AW:0] DEPTH_V = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic          clr_we;
  logic [AW-1:0] clr_addr;
  logic          busy;
  logic          access;
  logic          in_range;
  logic          wr_ok;
  logic          rd_ok;

  ram_clear_ctrl #(.DEPTH(DEPTH)) u_clear_ctrl (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (bus.clr),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .busy     (busy)
  );

  // clr wins over a same-cycle access; nothing is accepted while clearing.
  assign access   = !busy && bus.e && (bus.w || bus.r) && !bus.clr;
  assign in_range = ({1'b0, bus.addr} < DEPTH_V);
  assign wr_ok    = access && bus.w && in_range;
  assign rd_ok    = access && bus.r && in_range;

  // The array has no reset; contents survive reset until the clear pass.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (wr_ok) begin
      mem[bus.addr] <= bus.d;
    end
  end

  // Non-blocking read of mem gives read-first behaviour on a W&R cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out       <= '0;
      bus.out_valid <= 1'b0;
      bus.oor       <= 1'b0;
    end else begin
      bus.out_valid <= rd_ok;
      bus.oor       <= access && !in_range;
      if (rd_ok) begin
        bus.out <= mem[bus.addr];
      end
    end
  end

  assign bus.busy = busy;
endmodule
